// File: rtl/instr_mem_ctrl.sv
// Instruction-memory controller for the scalar unit: sequences program loads
// (valid/ready store stream) and PC-driven instruction fetch, one phase at a time.
module instr_mem_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Ld_Start,
  input  logic [ADDR_W-1:0]  I_Ld_Base,
  input  logic [ADDR_W:0]    I_Ld_Len,
  input  logic               I_St_Valid,
  input  logic [INSTR_W-1:0] I_St_Instr,
  output logic               O_St_Ready,
  output logic               O_Ld_Done,
  input  logic               I_Run,
  input  logic [ADDR_W-1:0]  I_Run_PC,
  input  logic               I_Fetch_Req,
  input  logic               I_Stall,
  input  logic               I_Branch,
  input  logic [ADDR_W-1:0]  I_Branch_PC,
  input  logic               I_Halt,
  output logic               O_Mem_Req_St,
  output logic [ADDR_W-1:0]  O_Mem_St_Addr,
  output logic [INSTR_W-1:0] O_Mem_St_Instr,
  output logic               O_Mem_Req_Ld,
  output logic [ADDR_W-1:0]  O_Mem_Ld_Addr,
  output logic               O_Fetch_Valid,
  output logic [ADDR_W-1:0]  O_Fetch_PC,
  output logic               O_Busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                ld_done_q;
  logic                fetch_valid_q;
  logic [ADDR_W-1:0]   fetch_pc_q;

  logic                st_accept;
  logic                fetch_issue;
  logic [ADDR_W-1:0]   ld_addr;
  logic [ADDR_W:0]     cnt_next;

  // Store and fetch are decoded from disjoint states, so the two memory
  // request strobes can never overlap.
  always_comb begin
    st_accept   = (state == LOAD) && I_St_Valid;
    fetch_issue = (state == RUN) && I_Fetch_Req && !I_Stall && !I_Halt;
    cnt_next    = cnt_q + CNT_ONE;
    ld_addr     = '0;
    if (fetch_issue) ld_addr = I_Branch ? I_Branch_PC : pc_q;
  end

  assign O_St_Ready     = (state == LOAD);
  assign O_Mem_Req_St   = st_accept;
  assign O_Mem_St_Addr  = st_accept ? (base_q + cnt_q[ADDR_W-1:0]) : '0;
  assign O_Mem_St_Instr = st_accept ? I_St_Instr : '0;
  assign O_Mem_Req_Ld   = fetch_issue;
  assign O_Mem_Ld_Addr  = ld_addr;
  assign O_Ld_Done      = ld_done_q;
  assign O_Fetch_Valid  = fetch_valid_q;
  assign O_Fetch_PC     = fetch_pc_q;
  assign O_Busy         = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      pc_q          <= '0;
      ld_done_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
    end else begin
      ld_done_q     <= 1'b0;
      fetch_valid_q <= fetch_issue;
      fetch_pc_q    <= ld_addr;
      unique case (state)
        IDLE: begin
          if (I_Ld_Start) begin
            if (I_Ld_Len != '0) begin
              state  <= LOAD;
              base_q <= I_Ld_Base;
              len_q  <= I_Ld_Len;
              cnt_q  <= '0;
            end else begin
              ld_done_q <= 1'b1;
            end
          end else if (I_Run) begin
            state <= RUN;
            pc_q  <= I_Run_PC;
          end
        end
        LOAD: begin
          if (st_accept) begin
            cnt_q <= cnt_next;
            if (cnt_next == len_q) begin
              state     <= IDLE;
              ld_done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (I_Halt) state <= IDLE;
          else if (fetch_issue) pc_q <= ld_addr + PC_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: drivers push expected stores, load-done
// pulses, reads and fetch returns (stamped with cycle); a negedge monitor pops them.
module tb_instr_mem_ctrl;
  localparam int AW    = 10;
  localparam int IW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          I_Ld_Start, I_St_Valid, I_Run, I_Fetch_Req, I_Stall, I_Branch, I_Halt;
  logic [AW-1:0] I_Ld_Base, I_Run_PC, I_Branch_PC;
  logic [AW:0]   I_Ld_Len;
  logic [IW-1:0] I_St_Instr;
  logic          O_St_Ready, O_Ld_Done, O_Mem_Req_St, O_Mem_Req_Ld, O_Fetch_Valid, O_Busy;
  logic [AW-1:0] O_Mem_St_Addr, O_Mem_Ld_Addr, O_Fetch_PC;
  logic [IW-1:0] O_Mem_St_Instr;

  instr_mem_ctrl #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clock(clock), .reset(reset),
    .I_Ld_Start(I_Ld_Start), .I_Ld_Base(I_Ld_Base), .I_Ld_Len(I_Ld_Len),
    .I_St_Valid(I_St_Valid), .I_St_Instr(I_St_Instr), .O_St_Ready(O_St_Ready),
    .O_Ld_Done(O_Ld_Done), .I_Run(I_Run), .I_Run_PC(I_Run_PC),
    .I_Fetch_Req(I_Fetch_Req), .I_Stall(I_Stall), .I_Branch(I_Branch),
    .I_Branch_PC(I_Branch_PC), .I_Halt(I_Halt),
    .O_Mem_Req_St(O_Mem_Req_St), .O_Mem_St_Addr(O_Mem_St_Addr), .O_Mem_St_Instr(O_Mem_St_Instr),
    .O_Mem_Req_Ld(O_Mem_Req_Ld), .O_Mem_Ld_Addr(O_Mem_Ld_Addr),
    .O_Fetch_Valid(O_Fetch_Valid), .O_Fetch_PC(O_Fetch_PC), .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {int cyc; int a; logic [IW-1:0] d;} ev_t;
  ev_t wq[$], dq[$], rq[$], fq[$];
  ev_t h;
  int  mpc;

  function automatic ev_t mk(int c, int a, logic [IW-1:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.d = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, logic [IW-1:0] act, logic [IW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    I_Ld_Start = 0; I_Ld_Base = '0; I_Ld_Len = '0; I_St_Valid = 0; I_St_Instr = '0;
    I_Run = 0; I_Run_PC = '0; I_Fetch_Req = 0; I_Stall = 0; I_Branch = 0;
    I_Branch_PC = '0; I_Halt = 0;
  endtask

  // Control inputs that must have no effect outside IDLE.
  task automatic noise();
    I_Run       = ($urandom % 3 == 0);
    I_Run_PC    = AW'($urandom);
    I_Fetch_Req = ($urandom % 2 == 0);
    I_Branch    = ($urandom % 3 == 0);
    I_Branch_PC = AW'($urandom);
  endtask

  task automatic do_load(int base, int len, bit rnd_gap, int gap_idx, int gap_n, bit with_run);
    I_Ld_Start = 1; I_Ld_Base = AW'(base); I_Ld_Len = (AW+1)'(len);
    I_Run = with_run; I_Run_PC = AW'($urandom);
    if (len == 0) dq.push_back(mk(cyc + 1, 0, '0));
    tick();
    idle_inputs();
    if (len == 0) begin
      chk("len0_ready", O_St_Ready, 0);
      chk("len0_busy", O_Busy, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      int g;
      g = rnd_gap ? (($urandom % 3 == 0) ? int'($urandom_range(1, 2)) : 0) : ((i == gap_idx) ? gap_n : 0);
      for (int k = 0; k < g; k++) begin
        noise();
        I_Ld_Start = ($urandom % 2 == 0); I_Ld_Len = (AW+1)'($urandom_range(1, 8));
        I_Ld_Base = AW'($urandom);
        I_St_Valid = 0; I_St_Instr = {$urandom, $urandom};
        tick();
        chk("load_busy", O_Busy, 1);
      end
      noise();
      I_Ld_Start = 0;
      I_St_Valid = 1; I_St_Instr = {$urandom, $urandom};
      wq.push_back(mk(cyc, (base + i) % DEPTH, I_St_Instr));
      if (i == len - 1) dq.push_back(mk(cyc + 1, 0, '0));
      tick();
    end
    idle_inputs();
    chk("load_end_busy", O_Busy, 0);
  endtask

  task automatic start_run(int pc);
    I_Run = 1; I_Run_PC = AW'(pc); mpc = pc;
    tick();
    idle_inputs();
    chk("run_busy", O_Busy, 1);
  endtask

  task automatic run_step(bit req, bit stall, bit br, int bpc, bit halt);
    int addr;
    I_Fetch_Req = req; I_Stall = stall; I_Branch = br; I_Branch_PC = AW'(bpc); I_Halt = halt;
    I_Ld_Start = ($urandom % 4 == 0); I_Ld_Len = (AW+1)'($urandom_range(1, 9));
    I_Ld_Base = AW'($urandom); I_Run = ($urandom % 4 == 0); I_Run_PC = AW'($urandom);
    I_St_Valid = ($urandom % 2 == 0); I_St_Instr = {$urandom, $urandom};
    if (req && !stall && !halt) begin
      addr = br ? bpc : mpc;
      rq.push_back(mk(cyc, addr, '0));
      fq.push_back(mk(cyc + 1, addr, '0));
      mpc = (addr + 1) % DEPTH;
    end
    tick();
  endtask

  task automatic end_run();
    run_step(1, 0, 0, 0, 1);
    idle_inputs();
    chk("halt_busy", O_Busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      if (O_Mem_Req_St || (wq.size() > 0 && wq[0].cyc <= cyc)) begin
        compared++;
        if (wq.size() > 0 && wq[0].cyc <= cyc) h = wq.pop_front(); else h = mk(-1, -1, '0);
        if (!(O_Mem_Req_St && h.cyc == cyc && int'(O_Mem_St_Addr) == h.a && O_Mem_St_Instr == h.d)) begin
          mismatched++;
          $display("FAIL store: cycle %0d got req=%b addr=%0h data=%0h expected cycle %0d addr=%0h data=%0h",
                   cyc, O_Mem_Req_St, O_Mem_St_Addr, O_Mem_St_Instr, h.cyc, h.a, h.d);
        end
      end
      if (O_Ld_Done || (dq.size() > 0 && dq[0].cyc <= cyc)) begin
        compared++;
        if (dq.size() > 0 && dq[0].cyc <= cyc) h = dq.pop_front(); else h = mk(-1, 0, '0);
        if (!(O_Ld_Done && h.cyc == cyc)) begin
          mismatched++;
          $display("FAIL ld_done: cycle %0d got %b expected pulse at cycle %0d", cyc, O_Ld_Done, h.cyc);
        end
      end
      if (O_Mem_Req_Ld || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
        compared++;
        if (rq.size() > 0 && rq[0].cyc <= cyc) h = rq.pop_front(); else h = mk(-1, -1, '0);
        if (!(O_Mem_Req_Ld && h.cyc == cyc && int'(O_Mem_Ld_Addr) == h.a)) begin
          mismatched++;
          $display("FAIL read: cycle %0d got req=%b addr=%0h expected cycle %0d addr=%0h",
                   cyc, O_Mem_Req_Ld, O_Mem_Ld_Addr, h.cyc, h.a);
        end
      end
      if (O_Fetch_Valid || (fq.size() > 0 && fq[0].cyc <= cyc)) begin
        compared++;
        if (fq.size() > 0 && fq[0].cyc <= cyc) h = fq.pop_front(); else h = mk(-1, -1, '0);
        if (!(O_Fetch_Valid && h.cyc == cyc && int'(O_Fetch_PC) == h.a)) begin
          mismatched++;
          $display("FAIL fetch_ret: cycle %0d got valid=%b pc=%0h expected cycle %0d pc=%0h",
                   cyc, O_Fetch_Valid, O_Fetch_PC, h.cyc, h.a);
        end
      end
      if (O_Mem_Req_St && O_Mem_Req_Ld) begin
        compared++;
        mismatched++;
        $display("FAIL req_excl: cycle %0d got st=1 ld=1 required at most one", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    repeat (2) tick();
    chk("rst_busy", O_Busy, 0);
    chk("rst_ready", O_St_Ready, 0);
    chk("rst_done", O_Ld_Done, 0);
    chk("rst_fvalid", O_Fetch_Valid, 0);
    chk("rst_fpc", O_Fetch_PC, 0);
    chk("rst_req_ld", O_Mem_Req_Ld, 0);
    reset = 1;
    tick();

    // Wrapping load with a two-cycle gap after the second beat
    do_load('h3FE, 4, 0, 2, 2, 0);
    // Zero-length load with a simultaneous run request (dropped)
    do_load(5, 0, 0, -1, 0, 1);
    // Ld_Start wins over a simultaneous run request
    do_load(100, 3, 1, -1, 0, 1);

    // Sequential fetch with a stall, branch, ignored branch, halt with fetch in flight
    start_run('h010);
    run_step(1, 0, 0, 0, 0);
    run_step(1, 1, 1, 'h155, 0);
    run_step(1, 0, 0, 0, 0);
    run_step(1, 0, 0, 0, 0);
    run_step(1, 0, 1, 'h200, 0);
    run_step(1, 0, 0, 0, 0);
    run_step(0, 0, 1, 'h155, 0);
    run_step(1, 0, 0, 0, 0);
    end_run();

    // PC wrap
    start_run('h3FE);
    repeat (4) run_step(1, 0, 0, 0, 0);
    end_run();

    // Randomized mix
    repeat (25) begin
      if ($urandom % 2 == 0) begin
        do_load(int'($urandom % DEPTH), int'($urandom_range(0, 6)), 1, -1, 0, ($urandom % 2 == 0));
      end else begin
        start_run(int'($urandom % DEPTH));
        repeat ($urandom_range(3, 15))
          run_step(($urandom % 4 != 0), ($urandom % 4 == 0), ($urandom % 5 == 0),
                   int'($urandom % DEPTH), 0);
        end_run();
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset after 2 of 5 beats
    I_Ld_Start = 1; I_Ld_Base = AW'('h120); I_Ld_Len = (AW+1)'(5);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      I_St_Valid = 1; I_St_Instr = {$urandom, $urandom};
      wq.push_back(mk(cyc, 'h120 + i, I_St_Instr));
      tick();
    end
    I_St_Valid = 1; I_St_Instr = {$urandom | 32'h1, $urandom};
    #2 reset = 0;
    #1;
    chk("arst_ready", O_St_Ready, 0);
    chk("arst_req_st", O_Mem_Req_St, 0);
    chk("arst_st_addr", O_Mem_St_Addr, 0);
    chk("arst_st_instr", O_Mem_St_Instr, 0);
    chk("arst_busy", O_Busy, 0);
    chk("arst_done", O_Ld_Done, 0);
    idle_inputs();
    repeat (2) tick();
    reset = 1;
    tick();
    do_load('h2A0, 3, 0, -1, 0, 0);

    // Full-depth load
    do_load(int'($urandom % DEPTH), DEPTH, 0, -1, 0, 0);

    repeat (3) tick();
    chk("left_stores", wq.size(), 0);
    chk("left_done", dq.size(), 0);
    chk("left_reads", rq.size(), 0);
    chk("left_fetch", fq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
